scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: cycles without refresh before a digit's valid flag drops; legal range 16..65535.
REQ-003 Port list, one per line:
  clk  input  1  single clock, all logic on rising edge
  reset  input  1  synchronous, active-high
  an  input  4  active-low digit-select lines of a scanned display
  seg  input  7  active-low segment lines, bit 0 = segment a
  digit0_seg..digit3_seg  output  7 each  last captured segment pattern per digit, active-low
  valid  output  4  bit n = digit n captured and refreshed within TIMEOUT_CYCLES
  cur_idx  output  2  index of the digit currently being captured or held
  blank  output  1  registered an == 4'b1111
  err_pulse  output  1  one-cycle pulse on entry into an illegal anode pattern
  err_count  output  8  saturating count of illegal-pattern entries

Function
REQ-004 Inputs an and seg SHALL be registered once (r_an, r_seg) before any decode.
REQ-005 Decode of r_an SHALL be: 1110->idx 0, 1101->idx 1, 1011->idx 2, 0111->idx 3, 1111->blank, every other value->illegal.
REQ-006 An 8-bit stability counter SHALL clear when {an,seg} differs from {r_an,r_seg} and otherwise increment, saturating at STABLE_CYCLES.
REQ-007 FSM states SHALL be IDLE, SETTLE, HOLD.
REQ-008 IDLE: entered on reset, blank or illegal pattern; goes to SETTLE when the registered pattern is a legal single digit.
REQ-009 SETTLE: on the edge where the counter reaches STABLE_CYCLES with a legal pattern, write r_seg into digitN_seg for the decoded idx, set valid[idx], reload that digit's timeout counter, go to HOLD.
REQ-010 SETTLE: if the pattern changes before capture, remain in SETTLE (new legal digit) or go to IDLE (blank/illegal); no capture.
REQ-011 HOLD: remain while the pattern is unchanged; on any change go to SETTLE (legal digit) or IDLE (blank/illegal); a seg change under the same anode SHALL re-enter SETTLE and recapture.
REQ-012 Capture latency: if edge k is the first to register a new stable legal pattern, digitN_seg and valid[N] SHALL update at edge k+STABLE_CYCLES.
REQ-013 cur_idx SHALL follow the decoded idx in SETTLE and HOLD and hold its last value in IDLE.
REQ-014 Each digit SHALL own a 16-bit down-counter reloaded to TIMEOUT_CYCLES-1 on capture; at zero, valid[n] clears and the counter stops.
REQ-015 Capture and timeout expiry for the same digit on the same edge: capture wins, valid stays 1.
REQ-016 err_pulse SHALL assert for exactly one cycle on the edge the registered pattern becomes illegal from a non-illegal or different pattern; err_count increments on the same edge and saturates at 255.
REQ-017 digitN_seg SHALL retain the last captured value after valid[n] drops.

Reset
REQ-018 On reset: state IDLE, digitN_seg = 7'b1111111, valid = 0, cur_idx = 0, blank = 0, err_pulse = 0, err_count = 0, all counters 0, r_an = 4'b1111, r_seg = 7'b1111111.
REQ-019 Reset asserted mid-capture SHALL abort the capture with no partial write.

Structure
REQ-020 Shared package scan_pkg SHALL hold the anode pattern constants, the FSM state enumeration and the blank segment constant.
REQ-021 Anode decode SHALL be the combinational sub-module anode_decode (in 4, out idx 2, legal 1, blank 1); all else stays in scan_decoder.

Verification
REQ-022 an=1110, seg=7'b1000000 held 10 cycles -> digit0_seg=1000000 and valid=0001 exactly STABLE_CYCLES edges after first registration.
REQ-023 Alternate an 1110/1101 every 3 cycles -> no capture, valid stays 0000; then hold 1101, seg=0100100 -> digit1_seg=0100100, valid[1]=1.
REQ-024 an=1100 for 2 cycles -> single err_pulse, err_count=1, FSM IDLE; repeat 300 times -> err_count=255.
REQ-025 TIMEOUT_CYCLES=16, capture digit 2, then an=1111 -> valid[2] clears 16 cycles after capture, digit2_seg retained.
REQ-026 Refresh capture on the timeout-expiry edge -> valid[n] stays 1.
REQ-027 reset pulsed on the capture edge -> all outputs at reset values, digit unchanged at 1111111.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the scanned-display decoder.
package scan_pkg;
    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_D1    = 4'b1101;
    localparam logic [3:0] AN_D2    = 4'b1011;
    localparam logic [3:0] AN_D3    = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;
endpackage

// File: rtl/anode_decode.sv
// Maps an active-low anode pattern to a digit index, or flags blank/illegal.
import scan_pkg::*;

module anode_decode (
    input  logic [3:0] an,
    output logic [1:0] idx,
    output logic       legal,
    output logic       blank
);
    always_comb begin
        idx   = 2'd0;
        legal = 1'b0;
        blank = 1'b0;
        case (an)
            AN_D0:    begin idx = 2'd0; legal = 1'b1; end
            AN_D1:    begin idx = 2'd1; legal = 1'b1; end
            AN_D2:    begin idx = 2'd2; legal = 1'b1; end
            AN_D3:    begin idx = 2'd3; legal = 1'b1; end
            AN_BLANK: blank = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: rtl/scan_decoder.sv
// Recovers per-digit segment patterns from a multiplexed 4-digit display bus,
// capturing only after the bus has been stable and aging out stale digits.
import scan_pkg::*;

module scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    output logic [6:0] digit0_seg,
    output logic [6:0] digit1_seg,
    output logic [6:0] digit2_seg,
    output logic [6:0] digit3_seg,
    output logic [3:0] valid,
    output logic [1:0] cur_idx,
    output logic       blank,
    output logic       err_pulse,
    output logic [7:0] err_count
);
    localparam logic [7:0]  STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_M1 = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYCLES - 1);

    logic [3:0]       r_an, p_an;
    logic [6:0]       r_seg;
    logic [7:0]       cnt;
    state_t           state;
    logic [3:0][6:0]  digit;
    logic [3:0][15:0] tmo;

    logic [1:0] idx;
    logic       legal, dec_blank, illegal, same, capture;

    anode_decode u_dec (
        .an    (r_an),
        .idx   (idx),
        .legal (legal),
        .blank (dec_blank)
    );

    assign illegal = !legal && !dec_blank;
    // "same" means the pattern about to be registered matches the current one.
    assign same    = ({an, seg} == {r_an, r_seg});
    assign capture = (state == SETTLE) && legal && same && (cnt >= STABLE_M1);

    assign digit0_seg = digit[0];
    assign digit1_seg = digit[1];
    assign digit2_seg = digit[2];
    assign digit3_seg = digit[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an      <= AN_BLANK;
            p_an      <= AN_BLANK;
            r_seg     <= SEG_BLANK;
            cnt       <= 8'd0;
            state     <= IDLE;
            digit     <= {4{SEG_BLANK}};
            tmo       <= '0;
            valid     <= 4'b0000;
            cur_idx   <= 2'd0;
            blank     <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            r_an  <= an;
            r_seg <= seg;
            p_an  <= r_an;
            blank <= dec_blank;

            if (!same)             cnt <= 8'd0;
            else if (cnt != STABLE) cnt <= cnt + 8'd1;

            // p_an lets us fire once per entry, including illegal-to-other-illegal.
            err_pulse <= illegal && (r_an != p_an);
            if (illegal && (r_an != p_an) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;

            case (state)
                IDLE: begin
                    if (legal) begin
                        state   <= SETTLE;
                        cur_idx <= idx;
                    end
                end
                SETTLE: begin
                    if (!legal) state <= IDLE;
                    else begin
                        cur_idx <= idx;
                        if (capture) state <= HOLD;
                    end
                end
                HOLD: begin
                    // cnt is zero only right after the registered pattern changed.
                    if (!legal) state <= IDLE;
                    else if (cnt == 8'd0) begin
                        state   <= SETTLE;
                        cur_idx <= idx;
                    end
                end
                default: state <= IDLE;
            endcase

            if (capture) digit[idx] <= r_seg;

            for (int n = 0; n < 4; n++) begin
                if (capture && (idx == 2'(n))) begin
                    tmo[n]   <= TMO_LOAD;
                    valid[n] <= 1'b1;
                end else if (tmo[n] != 16'd0) begin
                    tmo[n] <= tmo[n] - 16'd1;
                end else begin
                    valid[n] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: capture latency, debounce, errors, timeout, reset.
module tb_scan_decoder;
    localparam int S = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] digit0_seg, digit1_seg, digit2_seg, digit3_seg;
    logic [3:0] valid;
    logic [1:0] cur_idx;
    logic       blank, err_pulse;
    logic [7:0] err_count;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .seg        (seg),
        .digit0_seg (digit0_seg),
        .digit1_seg (digit1_seg),
        .digit2_seg (digit2_seg),
        .digit3_seg (digit3_seg),
        .valid      (valid),
        .cur_idx    (cur_idx),
        .blank      (blank),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; an = 4'b1111; seg = 7'b1111111;
        step(2);
        chk("rst_d0", 32'(digit0_seg), 32'h7F);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_idx", 32'(cur_idx), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        reset = 1'b0;

        // capture exactly S edges after first registration
        an = 4'b1110; seg = 7'b1000000;
        step(S);
        chk("d0_early_valid", 32'(valid), 32'h0);
        step(1);
        chk("d0_valid", 32'(valid), 32'h1);
        chk("d0_seg", 32'(digit0_seg), 32'h40);
        chk("d0_idx", 32'(cur_idx), 32'h0);
        step(5);
        chk("d0_blank", 32'(blank), 32'h0);

        // fast alternation must never capture
        reset = 1'b1; step(1); reset = 1'b0;
        chk("post_rst_blank", 32'(blank), 32'h0);
        step(1);
        chk("blank_reg", 32'(blank), 32'h1);
        seg = 7'b1111001;
        for (int i = 0; i < 6; i++) begin
            an = (i % 2 == 1) ? 4'b1101 : 4'b1110;
            step(3);
        end
        chk("alt_valid", 32'(valid), 32'h0);
        an = 4'b1101; seg = 7'b0100100;
        step(S);
        chk("d1_early", 32'(digit1_seg), 32'h7F);
        step(1);
        chk("d1_seg", 32'(digit1_seg), 32'h24);
        chk("d1_valid", 32'(valid), 32'h2);
        chk("d1_idx", 32'(cur_idx), 32'h1);

        // illegal anode pattern: single pulse, saturating count
        an = 4'b1100;
        step(1);
        chk("err_pre", 32'(err_pulse), 32'h0);
        step(1);
        chk("err_pulse", 32'(err_pulse), 32'h1);
        chk("err_cnt1", 32'(err_count), 32'h1);
        an = 4'b1111;
        step(1);
        chk("err_one_cycle", 32'(err_pulse), 32'h0);
        chk("err_idx_hold", 32'(cur_idx), 32'h1);
        step(1);
        for (int i = 0; i < 299; i++) begin
            an = 4'b1100; step(2);
            an = 4'b1111; step(2);
        end
        chk("err_sat", 32'(err_count), 32'hFF);

        // timeout after capture of digit 2
        an = 4'b1011; seg = 7'b0000010;
        step(S + 1);
        chk("d2_valid", 32'(valid[2]), 32'h1);
        chk("d2_idx", 32'(cur_idx), 32'h2);
        an = 4'b1111;
        step(T - 1);
        chk("d2_before_to", 32'(valid[2]), 32'h1);
        step(1);
        chk("d2_timeout", 32'(valid[2]), 32'h0);
        chk("d2_retained", 32'(digit2_seg), 32'h02);
        chk("d2_idx_idle", 32'(cur_idx), 32'h2);

        // refresh capture lands on the expiry edge
        an = 4'b0111; seg = 7'b0010010;
        step(S + 1);
        chk("d3_valid", 32'(valid[3]), 32'h1);
        an = 4'b1111;
        step(11);
        an = 4'b0111;
        step(S);
        chk("d3_pre_expiry", 32'(valid[3]), 32'h1);
        step(1);
        chk("d3_refresh_edge", 32'(valid[3]), 32'h1);
        step(1);
        chk("d3_after_refresh", 32'(valid[3]), 32'h1);

        // reset on the capture edge aborts the write
        reset = 1'b1; step(1); reset = 1'b0;
        an = 4'b1101; seg = 7'b0011001;
        step(S);
        reset = 1'b1;
        step(1);
        chk("abort_d1", 32'(digit1_seg), 32'h7F);
        chk("abort_d3", 32'(digit3_seg), 32'h7F);
        chk("abort_valid", 32'(valid), 32'h0);
        chk("abort_idx", 32'(cur_idx), 32'h0);
        chk("abort_blank", 32'(blank), 32'h0);
        chk("abort_errp", 32'(err_pulse), 32'h0);
        chk("abort_errc", 32'(err_count), 32'h0);
        reset = 1'b0; an = 4'b1111;
        step(2);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
